// File: rtl/sfifo_64i_16o_512.sv
`default_nettype none
// ============================================================================
// sfifo_64i_16o_512 : single-clock FIFO, 64-bit write side, 16-bit read side
// (little-endian lane order), with water levels, almost flags, ovf/udf pulses.
// Revision: 1.0
// ============================================================================
module sfifo_64i_16o_512 #(
  parameter int WR_DEPTH_WIDTH   = 7,
  parameter int RD_DEPTH_WIDTH   = 9,
  parameter int WR_DATA_WIDTH    = 64,
  parameter int RD_DATA_WIDTH    = 16,
  parameter int ALMOST_FULL_NUM  = 124,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                      clk,
  input  logic                      tb_rst,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                      wr_en,
  output logic                      wr_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic                      almost_full,
  output logic                      wr_ovf,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  input  logic                      rd_en,
  output logic                      rd_empty,
  output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
  output logic                      almost_empty,
  output logic                      rd_udf
);

  localparam int c_LANE_BITS = RD_DEPTH_WIDTH - WR_DEPTH_WIDTH;
  localparam int c_RATIO     = WR_DATA_WIDTH / RD_DATA_WIDTH;
  localparam int c_WR_DEPTH  = 1 << WR_DEPTH_WIDTH;
  localparam logic [WR_DEPTH_WIDTH:0] c_AF_LVL = (WR_DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [RD_DEPTH_WIDTH:0] c_AE_LVL = (RD_DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

  logic [WR_DATA_WIDTH-1:0]  mem_q [c_WR_DEPTH];
  logic [WR_DEPTH_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [RD_DEPTH_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [RD_DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                      wr_ovf_q, wr_ovf_d;
  logic                      rd_udf_q, rd_udf_d;

  logic [WR_DEPTH_WIDTH:0]                 w_rd_slot;
  logic [c_LANE_BITS-1:0]                  w_rd_lane;
  logic [c_RATIO-1:0][RD_DATA_WIDTH-1:0]   w_rd_beat;
  logic [WR_DEPTH_WIDTH:0]                 w_wr_lvl;
  logic [RD_DEPTH_WIDTH:0]                 w_rd_lvl;
  logic                                    w_full, w_empty, w_wr_acc, w_rd_acc;

  // Upper read-pointer bits name the 64-bit slot; a slot stays occupied
  // until its last lane has been read.
  assign w_rd_slot = rd_ptr_q[RD_DEPTH_WIDTH:c_LANE_BITS];
  assign w_rd_lane = rd_ptr_q[c_LANE_BITS-1:0];
  assign w_wr_lvl  = wr_ptr_q - w_rd_slot;
  assign w_rd_lvl  = {wr_ptr_q, {c_LANE_BITS{1'b0}}} - rd_ptr_q;
  assign w_full    = (wr_ptr_q[WR_DEPTH_WIDTH-1:0] == w_rd_slot[WR_DEPTH_WIDTH-1:0]) &&
                     (wr_ptr_q[WR_DEPTH_WIDTH] != w_rd_slot[WR_DEPTH_WIDTH]);
  assign w_empty   = (w_rd_lvl == '0);
  assign w_wr_acc  = wr_en && !w_full;
  assign w_rd_acc  = rd_en && !w_empty;
  assign w_rd_beat = mem_q[w_rd_slot[WR_DEPTH_WIDTH-1:0]];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    wr_ovf_d  = wr_en && w_full;
    rd_udf_d  = rd_en && w_empty;
    if (w_wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_rd_acc) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = w_rd_beat[w_rd_lane];
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
      wr_ovf_q  <= 1'b0;
      rd_udf_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
      wr_ovf_q  <= wr_ovf_d;
      rd_udf_q  <= rd_udf_d;
    end
  end

  // Storage is deliberately left out of reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      mem_q[wr_ptr_q[WR_DEPTH_WIDTH-1:0]] <= wr_data;
    end
  end

  assign wr_full        = w_full;
  assign wr_water_level = w_wr_lvl;
  assign almost_full    = (w_wr_lvl >= c_AF_LVL);
  assign wr_ovf         = wr_ovf_q;
  assign rd_data        = rd_data_q;
  assign rd_empty       = w_empty;
  assign rd_water_level = w_rd_lvl;
  assign almost_empty   = (w_rd_lvl <= c_AE_LVL);
  assign rd_udf         = rd_udf_q;

endmodule
`default_nettype wire

// File: tb/tb_sfifo_64i_16o_512.sv
`default_nettype none
// ============================================================================
// tb_sfifo_64i_16o_512 : scoreboard bench for the 64-in / 16-out FIFO.
// Revision: 1.0
// ============================================================================
module tb_sfifo_64i_16o_512;

  logic        clk = 1'b0;
  logic        tb_rst = 1'b1;
  logic [63:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic        wr_full;
  logic [7:0]  wr_water_level;
  logic        almost_full;
  logic        wr_ovf;
  logic [15:0] rd_data;
  logic        rd_en = 1'b0;
  logic        rd_empty;
  logic [9:0]  rd_water_level;
  logic        almost_empty;
  logic        rd_udf;

  always #5 clk = ~clk;

  sfifo_64i_16o_512 dut (
    .clk            (clk),
    .tb_rst         (tb_rst),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_full        (wr_full),
    .wr_water_level (wr_water_level),
    .almost_full    (almost_full),
    .wr_ovf         (wr_ovf),
    .rd_data        (rd_data),
    .rd_en          (rd_en),
    .rd_empty       (rd_empty),
    .rd_water_level (rd_water_level),
    .almost_empty   (almost_empty),
    .rd_udf         (rd_udf)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: beats written / words read, plus the word stream itself.
  int          nwr = 0;
  int          nrd = 0;
  logic [15:0] mdata[$];
  logic [15:0] exp_q[$];
  logic [15:0] m_last = '0;
  logic        pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wl();
    return nwr - nrd / 4;
  endfunction

  function automatic int rl();
    return 4 * nwr - nrd;
  endfunction

  task automatic check_state();
    chk("wr_full",        64'(wr_full),        64'(wl() == 128));
    chk("wr_water_level", 64'(wr_water_level), 64'(wl()));
    chk("almost_full",    64'(almost_full),    64'(wl() >= 124));
    chk("rd_empty",       64'(rd_empty),       64'(rl() == 0));
    chk("rd_water_level", 64'(rd_water_level), 64'(rl()));
    chk("almost_empty",   64'(almost_empty),   64'(rl() <= 4));
    chk("rd_data_hold",   64'(rd_data),        64'(m_last));
  endtask

  task automatic model_reset();
    nwr = 0;
    nrd = 0;
    mdata.delete();
    exp_q.delete();
    m_last = '0;
  endtask

  // One clock: present inputs, advance the model, check after the edge.
  task automatic step(input logic we, input logic [63:0] wd, input logic re);
    bit full, empty, e_ovf, e_udf;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    full  = (wl() == 128);
    empty = (rl() == 0);
    e_ovf = we && full;
    e_udf = re && empty;
    if (we && !full) begin
      for (int l = 0; l < 4; l++) mdata.push_back(wd[16*l +: 16]);
      nwr++;
    end
    if (re && !empty) begin
      m_last = mdata.pop_front();
      exp_q.push_back(m_last);
      nrd++;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("wr_ovf", 64'(wr_ovf), 64'(e_ovf));
    chk("rd_udf", 64'(rd_udf), 64'(e_udf));
    check_state();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_data"},  64'(rd_data),        64'd0);
    chk({tag, "_empty"},    64'(rd_empty),       64'd1);
    chk({tag, "_aempty"},   64'(almost_empty),   64'd1);
    chk({tag, "_full"},     64'(wr_full),        64'd0);
    chk({tag, "_afull"},    64'(almost_full),    64'd0);
    chk({tag, "_wlvl"},     64'(wr_water_level), 64'd0);
    chk({tag, "_rlvl"},     64'(rd_water_level), 64'd0);
    chk({tag, "_ovf"},      64'(wr_ovf),         64'd0);
    chk({tag, "_udf"},      64'(rd_udf),         64'd0);
  endtask

  // Monitor: a read accepted at an edge is checked at the following negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_data_seq: got %0d expected no read data at %0t", rd_data, $time);
        end else begin
          chk("rd_data_seq", 64'(rd_data), 64'(exp_q.pop_front()));
        end
      end
      pend = rd_en && !rd_empty && !tb_rst;
    end
  end

  initial begin
    logic [63:0] w;
    int pw, pr;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    tb_rst = 1'b0;
    step(1'b0, '0, 1'b0);

    // Fill with lane-indexed beats.
    for (int k = 0; k < 128; k++) begin
      w = {16'(4*k+3), 16'(4*k+2), 16'(4*k+1), 16'(4*k)};
      step(1'b1, w, 1'b0);
    end
    chk("full_wlvl", 64'(wr_water_level), 64'd128);
    chk("full_rlvl", 64'(rd_water_level), 64'd512);

    // Write into a full FIFO: dropped, one ovf pulse.
    step(1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    step(1'b0, '0, 1'b0);

    // Drain everything; full clears only when lane 3 of slot 0 is read.
    for (int i = 0; i < 512; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("udf_hold_511", 64'(rd_data), 64'd511);
    step(1'b0, '0, 1'b0);

    // Simultaneous write/read while empty: write lands, read rejected.
    step(1'b1, 64'h0004_0003_0002_0001, 1'b1);
    chk("sim_rlvl", 64'(rd_water_level), 64'd4);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // Randomised fill/drain phases to exercise wrap-around and full+read.
    for (int ph = 0; ph < 4; ph++) begin
      pw = (ph % 2 == 0) ? 60 : 10;
      pr = (ph % 2 == 0) ? 70 : 95;
      for (int i = 0; i < 250; i++) begin
        step(1'($urandom_range(0, 99) < pw), {$urandom, $urandom},
             1'($urandom_range(0, 99) < pr));
      end
    end
    for (int i = 0; i < 700 && rl() > 0; i++) step(1'b0, '0, 1'b1);

    // Reset in the middle of activity, between clock edges.
    for (int k = 0; k < 10; k++) step(1'b1, {$urandom, $urandom}, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    #2;
    tb_rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1;
    tb_rst = 1'b0;
    step(1'b0, '0, 1'b0);
    step(1'b1, 64'h1111_2222_3333_4444, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
